// File: rtl/activate_if.sv
// activate_if: handshake bundle between the activation stage, its
// consumer (res), the downstream error source (err) and the upstream
// associate error port (fbk).
interface activate_if;
  logic        train;
  logic        arg_valid;
  logic [15:0] arg_data;
  logic        arg_ready;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        res_ready;
  logic        err_valid;
  logic [15:0] err_data;
  logic        err_ready;
  logic        fbk_valid;
  logic [15:0] fbk_data;
  logic        fbk_ready;

  // Activation stage side
  modport slave (
    input  train, arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready,
    output arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data
  );

  // Environment side
  modport master (
    output train, arg_valid, arg_data, res_ready, err_valid, err_data, fbk_ready,
    input  arg_ready, res_valid, res_data, err_ready, fbk_valid, fbk_data
  );
endinterface

// File: rtl/activate.sv
// activate: Q8.8 inner product -> Q0.8 activation, with a training path
// that scales a downstream error by the activation derivative.
// Build option: define ACTIVATE_RELU_EN to use a clamped ReLU instead of
// the piecewise-linear sigmoid (default).
module activate (
  input  logic       clock,
  input  logic       reset,
  activate_if.slave  bus
);

  localparam int unsigned XW = 16;
  localparam int unsigned YW = 8;
  localparam int unsigned DW = 9;
  localparam int unsigned MW = 26;

  localparam logic [2:0] ST_ARG = 3'd0;
  localparam logic [2:0] ST_ACT = 3'd1;
  localparam logic [2:0] ST_RES = 3'd2;
  localparam logic [2:0] ST_ERR = 3'd3;
  localparam logic [2:0] ST_MUL = 3'd4;
  localparam logic [2:0] ST_FBK = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [XW-1:0] x_q;
  logic [XW-1:0] e_q;
  logic [YW-1:0] y_q;
  logic [DW-1:0] d_q;
  logic [YW-1:0] res_data_q;
  logic          res_valid_q;
  logic [XW-1:0] fbk_data_q;
  logic          fbk_valid_q;

  logic [YW-1:0]        y_c;
  logic [DW-1:0]        d_c;
  logic signed [MW-1:0] mul_c;
  logic [XW-1:0]        fbk_c;
  logic                 arg_fire_c;
  logic                 res_fire_c;
  logic                 err_fire_c;
  logic                 fbk_fire_c;

  assign bus.arg_ready = (state == ST_ARG);
  assign bus.err_ready = (state == ST_ERR);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.fbk_valid = fbk_valid_q;
  assign bus.fbk_data  = fbk_data_q;

  assign arg_fire_c = bus.arg_valid && (state == ST_ARG);
  assign err_fire_c = bus.err_valid && (state == ST_ERR);
  assign res_fire_c = res_valid_q && bus.res_ready && (state == ST_RES);
  assign fbk_fire_c = fbk_valid_q && bus.fbk_ready && (state == ST_FBK);

`ifdef ACTIVATE_RELU_EN
  // Clamped ReLU: pass 0 < x < 256 through with unit slope, else flat
  always_comb begin
    y_c = '0;
    d_c = '0;
    if (x_q[15] || (x_q == '0)) begin
      y_c = '0;
      d_c = '0;
    end else if (x_q < 16'h0100) begin
      y_c = x_q[7:0];
      d_c = 9'd256;
    end else begin
      y_c = 8'hFF;
      d_c = '0;
    end
  end
`else
  logic [XW-1:0] abs_c;
  logic [DW-1:0] p_c;
  logic [DW-1:0] yw_c;
  logic [16:0]   dprod_c;

  // Piecewise-linear sigmoid on |x|, mirrored for negative x; d = y(1-y)
  always_comb begin
    abs_c = x_q[15] ? XW'(~x_q + 16'd1) : x_q;
    if (abs_c < 16'h0100)      p_c = DW'(abs_c >> 2) + 9'd128;
    else if (abs_c < 16'h0260) p_c = DW'(abs_c >> 3) + 9'd160;
    else if (abs_c < 16'h0500) p_c = DW'(abs_c >> 5) + 9'd216;
    else                       p_c = 9'd256;
    yw_c    = x_q[15] ? (9'd256 - p_c) : p_c;
    y_c     = (yw_c > 9'd255) ? 8'hFF : yw_c[7:0];
    dprod_c = 17'(y_c) * (17'd256 - 17'(y_c));
    d_c     = DW'(dprod_c >> 8);
  end
`endif

  // Error times derivative, arithmetic shift back to Q8.8
  always_comb begin
    mul_c = MW'($signed(e_q)) * MW'($signed({1'b0, d_q}));
    fbk_c = XW'(mul_c >>> 8);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_ARG;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_ARG:  if (arg_fire_c) state_next = ST_ACT;
      ST_ACT:  state_next = ST_RES;
      ST_RES:  if (res_fire_c) state_next = bus.train ? ST_ERR : ST_ARG;
      ST_ERR:  if (err_fire_c) state_next = ST_MUL;
      ST_MUL:  state_next = ST_FBK;
      ST_FBK:  if (fbk_fire_c) state_next = ST_ARG;
      default: state_next = ST_ARG;
    endcase
  end

  // Operand latches, activation results and the registered output channels
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q         <= '0;
      e_q         <= '0;
      y_q         <= '0;
      d_q         <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      fbk_data_q  <= '0;
      fbk_valid_q <= 1'b0;
    end else begin
      if (arg_fire_c) x_q <= bus.arg_data;
      if (err_fire_c) e_q <= bus.err_data;
      if (state == ST_ACT) begin
        y_q <= y_c;
        d_q <= d_c;
      end
      if (state == ST_MUL) fbk_data_q <= fbk_c;

      if (state == ST_RES) begin
        if (!res_valid_q) begin
          res_valid_q <= 1'b1;
          res_data_q  <= y_q;
        end else if (bus.res_ready) begin
          res_valid_q <= 1'b0;
        end
      end else begin
        res_valid_q <= 1'b0;
      end

      if (state == ST_FBK) begin
        if (!fbk_valid_q)        fbk_valid_q <= 1'b1;
        else if (bus.fbk_ready)  fbk_valid_q <= 1'b0;
      end else begin
        fbk_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/activate.md
# activate

Nonlinear activation stage that sits directly downstream of the `associate` inner-product unit. It consumes the 16-bit signed Q8.8 inner product and emits an 8-bit unsigned Q0.8 activation, which is the argument format for the next layer. In training it accepts an error from downstream, scales it by the activation derivative, and returns the resulting 16-bit delta upstream on the `associate` error port.

## Interface
- No parameters; widths are fixed by the Q8.8 and Q0.8 formats.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `train`  in  1  training enable; sampled at the `res` handshake.
- `arg_valid`  in  1  inner product available.
- `arg_data`  in  16  signed Q8.8 inner product.
- `arg_ready`  out  1  high only in state ARG (combinational).
- `res_valid`  out  1  activation valid.
- `res_data`  out  8  unsigned Q0.8 activation, range 0..255.
- `res_ready`  in  1  consumer accepts the activation.
- `err_valid`  in  1  downstream error available.
- `err_data`  in  16  signed Q8.8 error.
- `err_ready`  out  1  high only in state ERR (combinational).
- `fbk_valid`  out  1  delta valid.
- `fbk_data`  out  16  signed Q8.8 delta, wired to `associate` `err_data`.
- `fbk_ready`  in  1  upstream accepts the delta.

## Operation
- **States:** ARG, ACT, RES, ERR, MUL, FBK.
- **Transitions:**
  - ARG→ACT on `arg_valid & arg_ready`. Latch x = `arg_data`.
  - ACT→RES unconditionally.
  - RES→ERR if `train`, else RES→ARG, on `res_valid & res_ready`.
  - ERR→MUL on `err_valid & err_ready`. Latch e = `err_data`.
  - MUL→FBK unconditionally.
  - FBK→ARG on `fbk_valid & fbk_ready`.
- **ACT, sigmoid path (default), piecewise linear:**
  - a = |x| as unsigned 16 bits, so 0x8000 maps to 32768.
  - p = (a>>2)+128 if a<0x100.
  - p = (a>>3)+160 if a<0x260.
  - p = (a>>5)+216 if a<0x500.
  - p = 256 otherwise.
  - y = p if x≥0, else 256−p. Clamp y to 255.
  - Register y and d = (y·(256−y))>>8, with d in 0..64.
- **MUL:** fbk = (e·d)>>>8, signed 24-bit intermediate. |fbk| ≤ 8192, so no saturation is needed; keep the low 16 bits.
- `res_data` is registered from y when `res_valid` rises. It holds stable while `res_valid` is high.
- `fbk_data` is registered from the MUL result. It holds stable in FBK.
- **Reset:**
  - state←ARG.
  - `res_valid`, `fbk_valid` ← 0.
  - x, y, d, e, `res_data`, `fbk_data` ← 0.
  - `arg_ready` is 1 from the first cycle after reset.
- **Reset mid-operation** in any state aborts the transaction. No partial handshake completes, and the pending output is dropped.
- **Invalid state encoding:** return to ARG.

## Timing
- `arg` handshake at edge t: ACT at t+1, RES entered at t+2, `res_valid` high from t+3.
- `res_valid` rises one cycle after RES is entered. It stays high until `res_ready`, then falls the next cycle along with the state change.
- `res_ready` may be held high constantly. Throughput without training is one sample per 4 cycles.
- `err` handshake at edge t: `fbk_valid` high from t+3, using the same registered-valid pattern as `res`.
- `arg_ready`/`err_ready` are low in every state other than their own. Inputs presented early are ignored until the owning state is reached.
- `train` changing outside the `res` handshake has no effect.
- Simultaneous `reset` and handshake: reset wins.

## Configuration
- `ACTIVATE_RELU_EN` defined: clamped ReLU replaces the sigmoid.
  - y = 0 if x ≤ 0; y = x if 0 < x < 256; y = 255 if x ≥ 256.
  - d = 256 when 0 < x < 256, else 0.
  - fbk = (e·d)>>>8, which equals e or 0.
- Undefined: the sigmoid approximation above; ReLU logic is absent.
- State machine, handshakes and latencies are identical in both builds.

## Test plan
- Sigmoid build, values 0x0000, 0x0100, 0xFF00, 0x0600, 0x8000, `train`=0 → `res_data` 0x80, 0xC0, 0x40, 0xFF, 0x00. Each `res_valid` rises 3 cycles after the `arg` handshake.
- Sigmoid build, breakpoint continuity: x=0x025F and 0x0260 → 0xEB for both; x=0x04FF and 0x0500 → 0xFF for both.
- Training, sigmoid: x=0x0000, `train`=1, e=0x0100 → `res_data` 0x80, then `fbk_data` 0x0040. With e=0x8000 → `fbk_data` 0xE000.
- Backpressure: hold `res_ready`=0 for 10 cycles, then `fbk_ready`=0 for 10 cycles.
  - `res_valid`, `fbk_valid` and their data stay constant.
  - `arg_ready`/`err_ready` stay 0.
  - Exactly one transfer occurs on release.
- Reset asserted in RES and again in FBK → next cycle all valids are 0, `arg_ready`=1, and no stale output appears afterwards.
- `ACTIVATE_RELU_EN` build: x=0x0000, 0x0080, 0x0200, 0xFF00 with e=0x0123 → `res_data` 0x00, 0x80, 0xFF, 0x00; `fbk_data` 0x0000, 0x0123, 0x0000, 0x0000.
